// File: rtl/mod_i2s_pkg.sv
// Shared I2S constants and types for the transmitter and receiver.
package mod_i2s_pkg;

    localparam int BITS_NO     = 16;
    localparam int FRAME_SLOTS = 32;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);

    // Slot indices; the MSB of each word trails its lrclk edge by one bclk.
    localparam logic [SLOT_W-1:0] SLOT_LEFT_MSB  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LR_SWITCH = SLOT_W'(BITS_NO);
    localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(FRAME_SLOTS - 1);

    typedef struct packed {
        logic [BITS_NO-1:0] left;
        logic [BITS_NO-1:0] right;
    } i2s_pair_t;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_t;

endpackage

// File: rtl/mod_i2s_clkgen.sv
// Bit-clock divider: bclk toggles every BCLK_DIV clk cycles; fall_evt flags
// the cycle whose closing edge takes bclk from 1 to 0.
module mod_i2s_clkgen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall_evt
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             wrap;

    // Next divider count and bclk level.
    always_comb begin
        wrap   = (div_q == DIV_LAST);
        div_d  = wrap ? '0 : div_q + 1'b1;
        bclk_d = wrap ? ~bclk_q : bclk_q;
    end

    // Divider and bclk registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk     = bclk_q;
    assign fall_evt = wrap & bclk_q;

endmodule

// File: rtl/mod_i2s_tx.sv
// I2S transmitter: single-entry pending buffer feeding a 32-bit shifter that
// is reloaded once per frame, on the bclk fall that enters slot 1.
module mod_i2s_tx
    import mod_i2s_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BITS_NO-1:0] in_left,
    input  logic [BITS_NO-1:0] in_right,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               bclk,
    output logic               lrclk,
    output logic               data_line,
    output logic               frame_start,
    output logic               underrun
);

    logic fall_evt;

    mod_i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

    pend_state_t            pst_q, pst_d;
    i2s_pair_t              pend_q, pend_d;
    logic [SLOT_W-1:0]      slot_q, slot_d, slot_nx;
    logic                   lrclk_q, lrclk_d;
    logic [FRAME_SLOTS-1:0] shift_q, shift_d;
    logic                   load, accept;

    assign slot_nx = slot_q + SLOT_W'(1);
    assign load    = fall_evt && (slot_nx == SLOT_LEFT_MSB);
    // rst gating keeps the handshake closed and the pulses quiet while held.
    assign in_ready    = (pst_q == PEND_EMPTY) && !rst;
    assign accept      = in_valid && in_ready;
    assign frame_start = load && !rst;
    assign underrun    = load && (pst_q == PEND_EMPTY) && !rst;
    assign data_line   = shift_q[FRAME_SLOTS-1];
    assign lrclk       = lrclk_q;

    // Pending buffer: a load drains it, an accept fills it; both may coincide
    // only when it is empty, so the load underruns and the new pair waits.
    always_comb begin
        pst_d  = pst_q;
        pend_d = pend_q;
        case (pst_q)
            PEND_EMPTY: begin
                if (accept) begin
                    pst_d  = PEND_FULL;
                    pend_d = '{left: in_left, right: in_right};
                end
            end
            PEND_FULL: begin
                if (load) pst_d = PEND_EMPTY;
            end
            default: pst_d = PEND_EMPTY;
        endcase
    end

    // Slot counter, word select and shifter all advance on bclk falls only.
    always_comb begin
        slot_d  = slot_q;
        lrclk_d = lrclk_q;
        shift_d = shift_q;
        if (fall_evt) begin
            slot_d  = slot_nx;
            lrclk_d = (slot_nx >= SLOT_LR_SWITCH);
            if (load)
                shift_d = (pst_q == PEND_FULL) ? {pend_q.left, pend_q.right} : '0;
            else
                shift_d = {shift_q[FRAME_SLOTS-2:0], 1'b0};
        end
    end

    // State registers; reset parks the frame in its last slot with lrclk high.
    always_ff @(posedge clk) begin
        if (rst) begin
            pst_q   <= PEND_EMPTY;
            pend_q  <= '0;
            slot_q  <= SLOT_LAST;
            lrclk_q <= 1'b1;
            shift_q <= '0;
        end else begin
            pst_q   <= pst_d;
            pend_q  <= pend_d;
            slot_q  <= slot_d;
            lrclk_q <= lrclk_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_mod_i2s_tx.sv
// Bench for mod_i2s_tx: a time-based reference model predicts every output each
// cycle; a bclk-rise receiver rebuilds transmitted words for end-to-end checks.
module tb_mod_i2s_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 64 * DIV;
    localparam logic [5:0] RST_VEC = 6'b010000; // bclk,lrclk,data,rdy,fs,ur

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_left = '0, in_right = '0;
    logic        in_ready, bclk, lrclk, data_line, frame_start, underrun;
    logic [5:0]  act;

    int n_cmp = 0;
    int n_bad = 0;

    mod_i2s_tx #(.BCLK_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .data_line   (data_line),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;
    assign act = {bclk, lrclk, data_line, in_ready, frame_start, underrun};

    // ---------------- reference model ----------------
    int          t = 0;        // clk edges since reset release
    int          slot = 31;
    bit          m_full = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_word = '0;  // word most recently loaded onto the line
    logic [31:0] loaded_q[$];
    logic [31:0] accepted_q[$];

    task automatic model_edge();
        bit ld, acc;
        if (rst) begin
            t = 0; slot = 31; m_full = 0; m_word = '0;
        end else begin
            t++;
            ld = 0;
            if (t % (2 * DIV) == 0) begin
                slot = (slot + 1) % 32;
                ld = (slot == 1);
            end
            acc = in_valid && !m_full;
            if (ld) begin
                m_word = m_full ? m_pend : 32'h0;
                loaded_q.push_back(m_word);
                m_full = 0;
            end
            if (acc) begin
                m_pend = {in_left, in_right};
                m_full = 1;
                accepted_q.push_back(m_pend);
            end
        end
    endtask

    function automatic logic [5:0] exp_vec();
        logic b, lr, d, rdy, fs, ur;
        b   = ((t / DIV) % 2) == 1;
        lr  = (slot >= 16);
        d   = m_word[31 - ((slot + 31) % 32)];
        rdy = !m_full && !rst;
        fs  = !rst && ((t + 1) % (2 * DIV) == 0) && (slot == 0);
        ur  = fs && !m_full;
        return {b, lr, d, rdy, fs, ur};
    endfunction

    // ---------------- receiver (samples on bclk rise) ----------------
    logic [31:0] rx_q[$];
    logic [31:0] rx_sr = '0;
    bit          rx_started = 0, rx_prev_b = 0, rx_prev_lr = 1;

    always @(negedge clk) begin
        if (rst) begin
            rx_q.delete();
            rx_started = 0; rx_prev_b = 0; rx_prev_lr = 1;
        end else begin
            if (bclk && !rx_prev_b) begin
                rx_sr = {rx_sr[30:0], data_line};
                if (!lrclk && rx_prev_lr) begin
                    if (rx_started) rx_q.push_back(rx_sr);
                    rx_started = 1;
                end
                rx_prev_lr = lrclk;
            end
            rx_prev_b = bclk;
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0;
        repeat (3) tick();
        rst = 0;
        loaded_q.delete();
        accepted_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; in_valid = 1; in_left = 16'h1234; in_right = 16'h5678;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (act !== RST_VEC) begin
                n_bad++; $display("FAIL reset cyc=%0d out=%b exp=%b", i, act, RST_VEC);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_timing();
        int first_fall, fall2, rise1, rise2;
        bit pb, plr;
        do_reset();
        first_fall = -1; fall2 = -1; rise1 = -1; rise2 = -1; pb = 0; plr = 1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++; $display("FAIL timing t=%0d out=%b exp=%b", t, act, exp_vec());
            end
            if (!lrclk && plr) begin
                if (first_fall < 0) first_fall = i; else if (fall2 < 0) fall2 = i;
            end
            if (bclk && !pb) begin
                if (rise1 < 0) rise1 = i; else if (rise2 < 0) rise2 = i;
            end
            pb = bclk; plr = lrclk;
        end
        n_cmp++;
        if (first_fall !== 2 * DIV) begin
            n_bad++; $display("FAIL first_lrclk_fall got=%0d exp=%0d", first_fall, 2 * DIV);
        end
        n_cmp++;
        if (rise2 - rise1 !== 2 * DIV) begin
            n_bad++; $display("FAIL bclk_period got=%0d exp=%0d", rise2 - rise1, 2 * DIV);
        end
        n_cmp++;
        if (fall2 - first_fall !== FRAME) begin
            n_bad++; $display("FAIL lrclk_period got=%0d exp=%0d", fall2 - first_fall, FRAME);
        end
    endtask

    task automatic test_known_pair();
        int n_fs, n_ur;
        do_reset();
        n_fs = 0; n_ur = 0;
        in_left = 16'hA5C3; in_right = 16'h0F01; in_valid = 1;
        for (int i = 0; i < 270; i++) begin
            tick();
            in_valid = 0;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++; $display("FAIL known_pair t=%0d out=%b exp=%b", t, act, exp_vec());
            end
            n_fs += int'(frame_start);
            n_ur += int'(underrun);
        end
        n_cmp++;
        if (n_fs !== 1 || n_ur !== 0) begin
            n_bad++; $display("FAIL known_pair_pulses fs=%0d ur=%0d exp fs=1 ur=0", n_fs, n_ur);
        end
        n_cmp++;
        if (rx_q.size() < 1 || rx_q[0] !== 32'hA5C30F01) begin
            n_bad++;
            $display("FAIL known_pair_word got=%h n=%0d exp=a5c30f01", (rx_q.size() > 0) ? rx_q[0] : 32'hx, rx_q.size());
        end
    endtask

    task automatic test_underrun();
        int n_ur, n_fs, n_ones;
        do_reset();
        n_ur = 0; n_fs = 0; n_ones = 0;
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            tick();
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++; $display("FAIL underrun t=%0d out=%b exp=%b", t, act, exp_vec());
            end
            n_ur += int'(underrun);
            n_fs += int'(frame_start);
            n_ones += int'(data_line);
        end
        n_cmp++;
        if (n_ur !== 3 || n_fs !== 3 || n_ones !== 0) begin
            n_bad++; $display("FAIL underrun_count ur=%0d fs=%0d ones=%0d exp 3 3 0", n_ur, n_fs, n_ones);
        end
    endtask

    task automatic test_loopback();
        logic [31:0] pairs[2];
        int k;
        pairs[0] = {16'h8000, 16'h7FFF};
        pairs[1] = {16'h0001, 16'hFFFF};
        do_reset();
        k = 0;
        for (int i = 0; i < 3 * FRAME + 20; i++) begin
            in_valid = (k < 2);
            if (k < 2) {in_left, in_right} = pairs[k];
            tick();
            if (accepted_q.size() > k) k = accepted_q.size();
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++; $display("FAIL loopback t=%0d out=%b exp=%b", t, act, exp_vec());
            end
        end
        in_valid = 0;
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if (rx_q.size() <= j || rx_q[j] !== pairs[j]) begin
                n_bad++;
                $display("FAIL loopback_word%0d got=%h exp=%h", j, (rx_q.size() > j) ? rx_q[j] : 32'hx, pairs[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_ur;
        do_reset();
        n_ur = 0;
        in_valid = 1;
        for (int i = 0; i < 5 * FRAME; i++) begin
            in_left = 16'($urandom); in_right = 16'($urandom);
            tick();
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++; $display("FAIL back_to_back t=%0d out=%b exp=%b", t, act, exp_vec());
            end
            n_ur += int'(underrun);
        end
        in_valid = 0;
        n_cmp++;
        if (n_ur !== 0 || rx_q.size() < 4) begin
            n_bad++; $display("FAIL b2b_flow ur=%0d words=%0d exp ur=0 words>=4", n_ur, rx_q.size());
        end
        for (int j = 0; j < rx_q.size(); j++) begin
            n_cmp++;
            if (j >= accepted_q.size() || rx_q[j] !== accepted_q[j]) begin
                n_bad++;
                $display("FAIL b2b_word%0d got=%h exp=%h", j, rx_q[j], (j < accepted_q.size()) ? accepted_q[j] : 32'hx);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4 * FRAME + 40; i++) begin
            in_valid = ($urandom_range(0, 99) < 2);
            in_left = 16'($urandom); in_right = 16'($urandom);
            tick();
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++; $display("FAIL random t=%0d out=%b exp=%b", t, act, exp_vec());
            end
        end
        in_valid = 0;
        for (int j = 0; j < rx_q.size(); j++) begin
            n_cmp++;
            if (j >= loaded_q.size() || rx_q[j] !== loaded_q[j]) begin
                n_bad++;
                $display("FAIL random_word%0d got=%h exp=%h", j, rx_q[j], (j < loaded_q.size()) ? loaded_q[j] : 32'hx);
            end
        end
    endtask

    task automatic test_mid_reset();
        int first_fall;
        bit hit, plr;
        do_reset();
        hit = 0;
        in_valid = 1;
        for (int i = 0; i < 400 && !hit; i++) begin
            in_left = 16'($urandom); in_right = 16'($urandom);
            tick();
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++; $display("FAIL mid_reset_pre t=%0d out=%b exp=%b", t, act, exp_vec());
            end
            hit = (slot == 10) && (t % (2 * DIV) == 3);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++; $display("FAIL mid_reset_reach slot10 got=0 exp=1");
        end
        rst = 1; in_valid = 0;
        tick();
        n_cmp++;
        if (act !== RST_VEC) begin
            n_bad++; $display("FAIL mid_reset_vals out=%b exp=%b", act, RST_VEC);
        end
        rst = 0;
        first_fall = -1; plr = 1;
        for (int i = 1; i <= FRAME + 40; i++) begin
            tick();
            n_cmp++;
            if (act !== exp_vec()) begin
                n_bad++; $display("FAIL mid_reset_post t=%0d out=%b exp=%b", t, act, exp_vec());
            end
            if (!lrclk && plr && first_fall < 0) first_fall = i;
            plr = lrclk;
        end
        n_cmp++;
        if (first_fall !== 2 * DIV) begin
            n_bad++; $display("FAIL mid_reset_restart got=%0d exp=%0d", first_fall, 2 * DIV);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_known_pair();
        test_underrun();
        test_loopback();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_i2s_tx.md
MOD_I2S_TX -- requirements
Module: mod_i2s_tx

Interface
REQ-001 Parameter BCLK_DIV, default 4, clk cycles per bclk half-period; legal values >=1.
REQ-002 clk  input  1  system clock; sole clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_left  input  16  left sample, two's complement, MSB first on the line.
REQ-005 in_right  input  16  right sample.
REQ-006 in_valid  input  1  sample pair offered.
REQ-007 in_ready  output  1  pending buffer empty; transfer when in_valid && in_ready on a clk edge.
REQ-008 bclk  output  1  I2S bit clock, registered.
REQ-009 lrclk  output  1  word select: 0 = left, 1 = right; registered.
REQ-010 data_line  output  1  serial data, registered.
REQ-011 frame_start  output  1  one-clk pulse when a sample pair is loaded into the shifter.
REQ-012 underrun  output  1  one-clk pulse when a load finds the pending buffer empty.

Function
REQ-013 Divider counts 0..BCLK_DIV-1; bclk toggles in the cycle the count reaches BCLK_DIV-1, then the count wraps to 0.
REQ-014 "Fall event" = clk cycle in which bclk toggles 1->0; lrclk, data_line and the slot counter change only on fall events.
REQ-015 Slot counter 0..31, increments on each fall event, wraps 31->0; frame = 32 bclk periods.
REQ-016 lrclk = 0 during slots 0..15 and 1 during slots 16..31.
REQ-017 Standard I2S one-bit delay: left MSB in slot 1, left LSB in slot 16, right MSB in slot 17, right LSB in slot 0 of the next frame.
REQ-018 32-bit shifter; data_line = shifter[31]; shifts left with 0 fill on every fall event except the load event.
REQ-019 Load event = fall event entering slot 1: shifter <= {pending_left, pending_right}; pending marked empty; frame_start pulses in that cycle.
REQ-020 Load with pending empty: shifter <= 0, underrun and frame_start both pulse; the line carries zeros for that frame.
REQ-021 Single-entry pending buffer; in_ready = !pending_full, combinational from the register.
REQ-022 Accept and load in the same cycle (buffer empty): load underruns; accepted pair fills pending for the next frame.
REQ-023 in_left/in_right/in_valid are ignored while in_ready = 0; an offered pair is never overwritten or lost.
REQ-024 Output stream is consumable by the team's I2S receiver sampling on bclk rising edge; bclk rise is mid-bit.

Reset
REQ-025 While rst = 1: divider 0, bclk 0, slot 31, lrclk 1, data_line 0, shifter 0, pending empty, in_ready 0, frame_start 0, underrun 0.
REQ-026 First fall event after rst release occurs 2*BCLK_DIV clk cycles later; it enters slot 0 with lrclk -> 0.
REQ-027 rst asserted mid-frame aborts the frame and discards the pending pair; no partial word is completed.

Structure
REQ-028 Shared include/package mod_i2s_pkg holds BITS_NO = 16, FRAME_SLOTS = 32 and slot-index constants; used by receiver and transmitter.
REQ-029 Divider and fall-event generation live in one sub-module, mod_i2s_clkgen (outputs bclk, fall_evt).

Verification
REQ-030 BCLK_DIV=4, rst release -> bclk period 8 clk; first lrclk fall 8 clk after release; lrclk period 256 clk.
REQ-031 Pair L=16'hA5C3, R=16'h0F01 offered before first load -> slot 1..16 bits 1010010111000011, slots 17..31,0 bits 0000111100000001; frame_start once; no underrun.
REQ-032 No in_valid for two frames -> underrun pulses at each slot-1 load; data_line constant 0.
REQ-033 Loopback into receiver, pairs (16'h8000,16'h7FFF) then (16'h0001,16'hFFFF) -> receiver data_left/data_right match, in order, one strobe each per frame.
REQ-034 in_valid held high with distinct pairs -> in_ready low between accept and load; each pair transmitted exactly once, none dropped.
REQ-035 rst pulsed during slot 10 -> all outputs at reset values the next cycle; next frame restarts per REQ-026.
